// File: rtl/pipelined_carry_adder.sv
// Pipelined add/subtract: the carry chain is cut into STAGES segments with a registered carry
// between them. Operands travel with the transaction (input skew) and the partial sum accumulates
// segment by segment (output deskew), so a whole result leaves the last stage at once.
module pipelined_carry_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_carry_adder: STAGES must divide WIDTH and lie in 1..WIDTH");
  end

  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned SEGW = SEG + 1;
  localparam int unsigned MSB  = WIDTH - 1;
  localparam int unsigned LAST = STAGES - 1;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  bp_q  [STAGES];
  logic [WIDTH-1:0]  bp_d  [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  // Inputs seen by each stage: stage 0 takes the conditioned ports, stage k the register of k-1.
  logic [STAGES-1:0] st_v;
  logic [STAGES-1:0] st_c;
  logic [WIDTH-1:0]  st_a   [STAGES];
  logic [WIDTH-1:0]  st_bp  [STAGES];
  logic [WIDTH-1:0]  st_sum [STAGES];

  logic stall;

  assign stall    = vld_q[LAST] && !out_ready;
  assign in_ready = !stall;

  always_comb begin
    st_v      = '0;
    st_c      = '0;
    st_a[0]   = a;
    st_bp[0]  = sub ? ~b : b;
    st_sum[0] = '0;
    st_v[0]   = in_valid;
    // Subtraction is a + ~b + ~cin, so the borrow-in becomes an inverted carry-in.
    st_c[0]   = cin ^ sub;
    for (int k = 1; k < STAGES; k++) begin
      st_v[k]   = vld_q[k-1];
      st_c[k]   = c_q[k-1];
      st_a[k]   = a_q[k-1];
      st_bp[k]  = bp_q[k-1];
      st_sum[k] = sum_q[k-1];
    end
  end

  always_comb begin
    logic [SEG:0] seg;
    seg    = '0;
    vld_d  = vld_q;
    c_d    = c_q;
    a_d    = a_q;
    bp_d   = bp_q;
    sum_d  = sum_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_d[k] = st_v[k];
        // Bubbles leave the data registers untouched so idle operands never reach the outputs.
        if (st_v[k]) begin
          seg = {1'b0, st_a[k][k*SEG +: SEG]} + {1'b0, st_bp[k][k*SEG +: SEG]}
              + SEGW'(st_c[k]);
          a_d[k]                 = st_a[k];
          bp_d[k]                = st_bp[k];
          sum_d[k]               = st_sum[k];
          sum_d[k][k*SEG +: SEG] = seg[SEG-1:0];
          c_d[k]                 = seg[SEG];
        end
      end
      if (st_v[LAST]) begin
        ovf_d  = (st_a[LAST][MSB] == st_bp[LAST][MSB]) && (sum_d[LAST][MSB] != st_a[LAST][MSB]);
        zero_d = (sum_d[LAST] == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      c_q    <= '0;
      a_q    <= '{default: '0};
      bp_q   <= '{default: '0};
      sum_q  <= '{default: '0};
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      c_q    <= c_d;
      a_q    <= a_d;
      bp_q   <= bp_d;
      sum_q  <= sum_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = vld_q[LAST];
  assign s         = sum_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Bench for pipelined_carry_adder: three instances (32/4, 8/1, 8/8) checked with directed
// vectors, random backpressured streams against an arithmetic model, and mid-flight reset.
module tb_pipelined_carry_adder;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  typedef struct {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid_v  [3];
  logic        in_ready_v  [3];
  logic        out_valid_v [3];
  logic        out_ready_v [3];
  logic [31:0] a_v         [3];
  logic [31:0] b_v         [3];
  logic        cin_v       [3];
  logic        sub_v       [3];
  logic        cout_v      [3];
  logic        ovf_v       [3];
  logic        zero_v      [3];
  logic [31:0] s0;
  logic [7:0]  s1, s2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_carry_adder #(.WIDTH(32), .STAGES(4)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]), .sub(sub_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .s(s0), .cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0])
  );

  pipelined_carry_adder #(.WIDTH(8), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1][7:0]), .b(b_v[1][7:0]), .cin(cin_v[1]), .sub(sub_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .s(s1), .cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1])
  );

  pipelined_carry_adder #(.WIDTH(8), .STAGES(8)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_v[2][7:0]), .b(b_v[2][7:0]), .cin(cin_v[2]), .sub(sub_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .s(s2), .cout(cout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2])
  );

  function automatic int wid(input int idx);
    return (idx == 0) ? 32 : 8;
  endfunction

  function automatic int stg(input int idx);
    return (idx == 0) ? 4 : ((idx == 1) ? 1 : 8);
  endfunction

  function automatic logic [31:0] get_s(input int idx);
    if (idx == 0) return s0;
    if (idx == 1) return {24'd0, s1};
    return {24'd0, s2};
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations of the operands.
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    res_t   r;
    longint mask, ua, ub, sa, sb, ur, sr, c;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
    sb   = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
    c    = cin ? 1 : 0;
    if (!sub) begin
      ur     = ua + ub + c;
      sr     = sa + sb + c;
      r.cout = (ur > mask);
    end else begin
      ur     = ua - ub - c;
      sr     = sa - sb - c;
      r.cout = (ua >= ub + c);
    end
    r.s    = 32'(ur & mask);
    r.ovf  = (sr > (mask >> 1)) || (sr < -((mask >> 1) + 1));
    r.zero = ((ur & mask) == 0);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_result(input string name, input int idx, input res_t e);
    check({name, ".s"}, get_s(idx), e.s);
    check({name, ".cout"}, 32'(cout_v[idx]), 32'(e.cout));
    check({name, ".ovf"}, 32'(ovf_v[idx]), 32'(e.ovf));
    check({name, ".zero"}, 32'(zero_v[idx]), 32'(e.zero));
  endtask

  task automatic reset_all(input int cycles);
    for (int i = 0; i < 3; i++) in_valid_v[i] = 1'b0;
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst.out_valid", 32'(out_valid_v[i]), 0);
      check("rst.s", get_s(i), 0);
      check("rst.cout", 32'(cout_v[i]), 0);
      check("rst.ovf", 32'(ovf_v[i]), 0);
      check("rst.zero", 32'(zero_v[i]), 0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check("rst.in_ready", 32'(in_ready_v[i]), 1);
  endtask

  // One isolated transaction: checks latency and the registered flags.
  task automatic apply_one(input vec_t v);
    res_t e;
    int   lat;
    e = '{s: v.s, cout: v.cout, ovf: v.ovf, zero: v.zero};
    out_ready_v[v.idx] = 1'b1;
    in_valid_v[v.idx]  = 1'b1;
    a_v[v.idx]   = v.a;
    b_v[v.idx]   = v.b;
    cin_v[v.idx] = v.cin;
    sub_v[v.idx] = v.sub;
    #1;
    check("vec.in_ready", 32'(in_ready_v[v.idx]), 1);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      if (lat == 0) begin
        in_valid_v[v.idx] = 1'b0;
        a_v[v.idx] = $urandom;
        b_v[v.idx] = $urandom;
      end
      lat++;
    end while (!out_valid_v[v.idx] && lat < 40);
    check("vec.latency", 32'(lat), 32'(stg(v.idx)));
    check_result("vec", v.idx, e);
    @(posedge clk);
    #1;
    check("vec.drained", 32'(out_valid_v[v.idx]), 0);
  endtask

  // Back-to-back random stream with out_ready low one cycle in three.
  task automatic run_stream(input int idx, input int n);
    res_t        q[$];
    res_t        e;
    int          sent, got, cyc;
    bit          held, acc;
    logic [31:0] hs;
    logic        hc, ho, hz, ov, rdy;
    sent = 0;
    got  = 0;
    held = 0;
    in_valid_v[idx] = 1'b1;
    a_v[idx]   = $urandom;
    b_v[idx]   = $urandom;
    cin_v[idx] = 1'($urandom_range(1));
    sub_v[idx] = 1'($urandom_range(1));
    for (cyc = 0; got < n && cyc < 500; cyc++) begin
      out_ready_v[idx] = (cyc % 3 != 2);
      #1;
      ov  = out_valid_v[idx];
      rdy = in_ready_v[idx];
      check("stream.in_ready", 32'(rdy), 32'(!(ov && !out_ready_v[idx])));
      if (held) begin
        check("stall.out_valid", 32'(ov), 1);
        check("stall.s", get_s(idx), hs);
        check("stall.flags", {29'd0, cout_v[idx], ovf_v[idx], zero_v[idx]}, {29'd0, hc, ho, hz});
      end
      held = ov && !out_ready_v[idx];
      hs = get_s(idx);
      hc = cout_v[idx];
      ho = ovf_v[idx];
      hz = zero_v[idx];
      if (ov && out_ready_v[idx]) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stream.spurious: got unexpected result 0x%0h required none", get_s(idx));
        end else begin
          e = q.pop_front();
          check_result("stream", idx, e);
        end
        got++;
      end
      acc = in_valid_v[idx] && rdy;
      if (acc) begin
        q.push_back(model(wid(idx), a_v[idx], b_v[idx], cin_v[idx], sub_v[idx]));
        sent++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        if (sent < n) begin
          a_v[idx]   = $urandom;
          b_v[idx]   = $urandom;
          cin_v[idx] = 1'($urandom_range(1));
          sub_v[idx] = 1'($urandom_range(1));
        end else begin
          in_valid_v[idx] = 1'b0;
          a_v[idx] = $urandom;
        end
      end
    end
    check("stream.count", 32'(got), 32'(n));
    check("stream.leftover", 32'(q.size()), 0);
    out_ready_v[idx] = 1'b1;
  endtask

  task automatic midflight_reset();
    out_ready_v[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid_v[0] = 1'b1;
      a_v[0] = $urandom;
      b_v[0] = $urandom;
      cin_v[0] = 1'b1;
      sub_v[0] = 1'b0;
      @(posedge clk);
      #1;
      check("mid.no_early", 32'(out_valid_v[0]), 0);
    end
    in_valid_v[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid.s_cleared", get_s(0), 0);
    for (int i = 0; i < 8; i++) begin
      check("mid.out_valid", 32'(out_valid_v[0]), 0);
      check("mid.in_ready", 32'(in_ready_v[0]), 1);
      @(posedge clk);
      #1;
    end
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1},
      '{0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0},
      '{0, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0},
      '{0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0},
      '{0, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1},
      '{0, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0},
      '{1, 32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1},
      '{1, 32'h0000_007F, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0080, 1'b0, 1'b1, 1'b0},
      '{2, 32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1},
      '{2, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b1, 32'h0000_00EF, 1'b0, 1'b0, 1'b0},
      '{2, 32'h0000_0080, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_007F, 1'b1, 1'b1, 1'b0}
    };
    for (int i = 0; i < 3; i++) begin
      in_valid_v[i]  = 1'b0;
      out_ready_v[i] = 1'b1;
      a_v[i]   = '0;
      b_v[i]   = '0;
      cin_v[i] = 1'b0;
      sub_v[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    reset_all(2);
    foreach (vecs[i]) apply_one(vecs[i]);
    run_stream(0, 20);
    midflight_reset();
    run_stream(1, 20);
    run_stream(2, 20);
    run_stream(0, 20);
    reset_all(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
